// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: write scoreboard, RAW stall detection and branch flush.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   id_valid                     - Decode holds a valid instruction
//   id_a1/a2/a3, id_use_a1/2/3   - Decode operand addresses and read enables
//   id_wre                       - Decode instruction writes id_a3
//   ex_branch_taken              - Execute redirects the PC this cycle
//   stall_pc, stall_fd           - hold PC / Fetch-Decode register
//   flush_fd, bubble_de          - NOP into Fetch-Decode / zero controls into Decode-Execute
//   busy_mask                    - registers with a pending write
//   state                        - 00 RUN, 01 STALL, 10 FLUSH
//   stall_count                  - saturating count of stall cycles
module pipeline_hazard_controller #(
    parameter int unsigned SB_DEPTH     = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_a1,
    input  logic [3:0]  id_a2,
    input  logic [3:0]  id_a3,
    input  logic        id_use_a1,
    input  logic        id_use_a2,
    input  logic        id_use_a3,
    input  logic        id_wre,
    input  logic        ex_branch_taken,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        flush_fd,
    output logic        bubble_de,
    output logic [15:0] busy_mask,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_count_q, stall_count_d;
    logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [3:0]         sb_addr_q [SB_DEPTH];
    logic [3:0]         sb_addr_d [SB_DEPTH];
    logic               hazard;
    logic               branch_act;
    logic               issue_vld;
    logic [15:0]        busy_raw;

    // Operand match against every valid slot; no forwarding, so any match stalls.
    always_comb begin
        hazard   = 1'b0;
        busy_raw = 16'h0000;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld_q[i]) begin
                busy_raw[sb_addr_q[i]] = 1'b1;
                if ((id_use_a1 && (id_a1 == sb_addr_q[i])) ||
                    (id_use_a2 && (id_a2 == sb_addr_q[i])) ||
                    (id_use_a3 && (id_a3 == sb_addr_q[i])))
                    hazard = 1'b1;
            end
        end
        hazard = hazard & id_valid & ~rst;
    end

    // Control outputs: branch/flush has priority over a data hazard; all forced low in reset.
    always_comb begin
        branch_act = ~rst & (ex_branch_taken | (state_q == ST_FLUSH));
        flush_fd   = branch_act;
        stall_pc   = hazard & ~branch_act;
        stall_fd   = hazard & ~branch_act;
        bubble_de  = branch_act | hazard;
        busy_mask  = rst ? 16'h0000 : busy_raw;
        issue_vld  = id_valid & id_wre & ~stall_fd & ~flush_fd;
    end

    // Scoreboard shift: slot0 takes the issued write, the last slot retires.
    always_comb begin
        sb_vld_d     = '0;
        sb_vld_d[0]  = issue_vld;
        sb_addr_d[0] = id_a3;
        for (int unsigned i = 1; i < SB_DEPTH; i++) begin
            sb_vld_d[i]  = sb_vld_q[i-1];
            sb_addr_d[i] = sb_addr_q[i-1];
        end
    end

    // Next-state logic; the counter holds the FLUSH-state cycles still to run.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_count_d = stall_count_q;
        if (stall_pc && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end else if (hazard) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (ex_branch_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end else if (!hazard) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (ex_branch_taken) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    // Decrement reaches zero: flush complete, hazards re-evaluated in RUN.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            stall_count_q <= 16'h0000;
            sb_vld_q      <= '0;
            for (int unsigned i = 0; i < SB_DEPTH; i++)
                sb_addr_q[i] <= 4'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            sb_vld_q      <= sb_vld_d;
            for (int unsigned i = 0; i < SB_DEPTH; i++)
                sb_addr_q[i] <= sb_addr_d[i];
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule
